alu_main: RTL and testbench

//  32-bit combinational ALU core with a registered result stage.

---
 rtl/alu_main.sv | 114 +++++++++++
 tb/tb_alu_main.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/alu_main.sv
// ---------------------------------------------------------------------------
// alu_main
//   32-bit ALU for the execute stage. The operation is evaluated
//   combinationally from A, B and OP, and the result and flags are registered
//   on the rising clock edge, so latency is exactly one cycle. A new operation
//   is accepted every cycle, and there is no handshake.
//
// Ports
//   clk   in   1   rising-edge clock
//   rst   in   1   asynchronous, active-high reset (OUT=0, zero=1, ovf=0)
//   A     in  32   operand A
//   B     in  32   operand B (shift amount is B[4:0])
//   OP    in   5   operation select (0x10-0x1F reserved -> result 0)
//   OUT   out 32   registered result
//   zero  out  1   registered, 1 when OUT == 0
//   ovf   out  1   registered signed overflow of ADD/SUB, else 0
// ---------------------------------------------------------------------------
module alu_main (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [4:0]  OP,
    output logic [31:0] OUT,
    output logic        zero,
    output logic        ovf
);

    typedef enum logic [4:0] {
        OP_AND   = 5'h00,
        OP_OR    = 5'h01,
        OP_ADD   = 5'h02,
        OP_XOR   = 5'h03,
        OP_NOR   = 5'h04,
        OP_SRL   = 5'h05,
        OP_SUB   = 5'h06,
        OP_SLT   = 5'h07,
        OP_SLL   = 5'h08,
        OP_SRA   = 5'h09,
        OP_SLTU  = 5'h0A,
        OP_ADDU  = 5'h0B,
        OP_SUBU  = 5'h0C,
        OP_LUI   = 5'h0D,
        OP_PASSA = 5'h0E,
        OP_PASSB = 5'h0F
    } op_e;

    logic [31:0] sum;
    logic [31:0] diff;
    logic [4:0]  shamt;
    logic        add_ovf;
    logic        sub_ovf;

    logic [31:0] out_d,  out_q;
    logic        zero_d, zero_q;
    logic        ovf_d,  ovf_q;

    // Shared adder/subtractor; the carry out of bit 31 is dropped.
    assign sum   = A + B;
    assign diff  = A - B;
    assign shamt = B[4:0];

    // Signed overflow occurs when the result sign disagrees with the operand signs.
    assign add_ovf = (A[31] == B[31]) && (sum[31]  != A[31]);
    assign sub_ovf = (A[31] != B[31]) && (diff[31] != A[31]);

    always_comb begin
        out_d = '0;
        ovf_d = 1'b0;
        case (op_e'(OP))
            OP_AND:   out_d = A & B;
            OP_OR:    out_d = A | B;
            OP_ADD: begin
                out_d = sum;
                ovf_d = add_ovf;
            end
            OP_XOR:   out_d = A ^ B;
            OP_NOR:   out_d = ~(A | B);
            OP_SRL:   out_d = A >> shamt;
            OP_SUB: begin
                out_d = diff;
                ovf_d = sub_ovf;
            end
            OP_SLT:   out_d = {31'b0, $signed(A) < $signed(B)};
            OP_SLL:   out_d = A << shamt;
            OP_SRA:   out_d = $signed(A) >>> shamt;
            OP_SLTU:  out_d = {31'b0, A < B};
            OP_ADDU:  out_d = sum;
            OP_SUBU:  out_d = diff;
            OP_LUI:   out_d = {B[15:0], 16'b0};
            OP_PASSA: out_d = A;
            OP_PASSB: out_d = B;
            default:  out_d = '0;  // reserved opcodes
        endcase
        zero_d = (out_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q  <= '0;
            zero_q <= 1'b1;
            ovf_q  <= 1'b0;
        end else begin
            out_q  <= out_d;
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
        end
    end

    assign OUT  = out_q;
    assign zero = zero_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_alu_main.sv
// ---------------------------------------------------------------------------
// tb_alu_main
//   Directed vectors with hand-computed expected results. The driver applies
//   the operands on the falling edge and queues the expected response. The
//   monitor pops and compares it one cycle later, just after the rising edge.
// ---------------------------------------------------------------------------
module tb_alu_main;

    logic        clk;
    logic        rst;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  OP;
    logic [31:0] OUT;
    logic        zero;
    logic        ovf;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] out;
        logic        z;
        logic        v;
        string       name;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  op;
        logic [31:0] out;
        logic        z;
        logic        v;
        string       name;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[$];

    alu_main dut (
        .clk  (clk),
        .rst  (rst),
        .A    (A),
        .B    (B),
        .OP   (OP),
        .OUT  (OUT),
        .zero (zero),
        .ovf  (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] o,
                         input logic z, input logic v, input exp_t e);
        tests++;
        if (o !== e.out || z !== e.z || v !== e.v) begin
            fails++;
            $display("FAIL %s: got OUT=%08h zero=%0b ovf=%0b, expected OUT=%08h zero=%0b ovf=%0b",
                     name, o, z, v, e.out, e.z, e.v);
        end
    endtask

    // Monitor: one registered result per rising edge while out of reset.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e.name, OUT, zero, ovf, e);
            end
        end
    end

    function automatic void addv(input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] op, input logic [31:0] out,
                                 input logic z, input logic v, input string name);
        vec_t t;
        t.a = a; t.b = b; t.op = op; t.out = out; t.z = z; t.v = v; t.name = name;
        vecs.push_back(t);
    endfunction

    initial begin
        exp_t e;
        addv(32'h0000_0002, 32'h0000_0002, 5'h01, 32'h0000_0002, 1'b0, 1'b0, "or_2_2");
        addv(32'h0000_0002, 32'h0000_0002, 5'h03, 32'h0000_0000, 1'b1, 1'b0, "xor_zero");
        addv(32'h7FFF_FFFF, 32'h0000_0001, 5'h02, 32'h8000_0000, 1'b0, 1'b1, "add_ovf");
        addv(32'h7FFF_FFFF, 32'h0000_0001, 5'h0B, 32'h8000_0000, 1'b0, 1'b0, "addu_no_ovf");
        addv(32'h8000_0000, 32'h0000_0001, 5'h06, 32'h7FFF_FFFF, 1'b0, 1'b1, "sub_ovf");
        addv(32'h8000_0000, 32'h0000_0001, 5'h07, 32'h0000_0001, 1'b0, 1'b0, "slt_neg");
        addv(32'h8000_0000, 32'h0000_0001, 5'h0A, 32'h0000_0000, 1'b1, 1'b0, "sltu_big");
        addv(32'h8000_0010, 32'h0000_0024, 5'h05, 32'h0800_0001, 1'b0, 1'b0, "srl_b5_ignored");
        addv(32'h8000_0010, 32'h0000_0024, 5'h09, 32'hF800_0001, 1'b0, 1'b0, "sra_sign_fill");
        addv(32'h8000_0010, 32'h0000_0024, 5'h08, 32'h0000_0100, 1'b0, 1'b0, "sll_drop");
        addv(32'h0000_0000, 32'h0000_ABCD, 5'h0D, 32'hABCD_0000, 1'b0, 1'b0, "lui");
        addv(32'h0000_0000, 32'h0000_ABCD, 5'h1F, 32'h0000_0000, 1'b1, 1'b0, "reserved_1f");
        addv(32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'h00, 32'h00F0_00F0, 1'b0, 1'b0, "and");
        addv(32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'h04, 32'h000F_000F, 1'b0, 1'b0, "nor");
        addv(32'h0000_0000, 32'h0000_0001, 5'h0C, 32'hFFFF_FFFF, 1'b0, 1'b0, "subu_wrap");
        addv(32'h8000_0000, 32'h8000_0000, 5'h02, 32'h0000_0000, 1'b1, 1'b1, "add_neg_ovf_zero");
        addv(32'h0000_0005, 32'h0000_0007, 5'h06, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub_no_ovf");
        addv(32'h8000_0000, 32'hFFFF_FFE1, 5'h09, 32'hC000_0000, 1'b0, 1'b0, "sra_high_b_ignored");
        addv(32'hFFFF_FFFF, 32'h0000_0001, 5'h07, 32'h0000_0001, 1'b0, 1'b0, "slt_m1_lt_1");
        addv(32'hFFFF_FFFF, 32'h0000_0001, 5'h0A, 32'h0000_0000, 1'b1, 1'b0, "sltu_m1");
        addv(32'h1234_5678, 32'hDEAD_BEEF, 5'h0E, 32'h1234_5678, 1'b0, 1'b0, "passa");
        addv(32'h1234_5678, 32'hDEAD_BEEF, 5'h0F, 32'hDEAD_BEEF, 1'b0, 1'b0, "passb");
        addv(32'h0000_0005, 32'h0000_0007, 5'h10, 32'h0000_0000, 1'b1, 1'b0, "reserved_10");

        // Hold reset with an ADD pending and clocks running.
        rst = 1'b1;
        A   = 32'd5;
        B   = 32'd7;
        OP  = 5'h02;
        e.out = '0; e.z = 1'b1; e.v = 1'b0; e.name = "reset_hold";
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold", OUT, zero, ovf, e);
        end

        @(negedge clk);
        rst = 1'b0;
        e.out = 32'd12; e.z = 1'b0; e.v = 1'b0; e.name = "first_after_reset";
        exp_q.push_back(e);

        foreach (vecs[i]) begin
            @(negedge clk);
            A  = vecs[i].a;
            B  = vecs[i].b;
            OP = vecs[i].op;
            e.out = vecs[i].out; e.z = vecs[i].z; e.v = vecs[i].v; e.name = vecs[i].name;
            exp_q.push_back(e);
        end

        // Load a nonzero result, then assert reset between edges.
        @(negedge clk);
        A  = 32'h0;
        B  = 32'h0000_1234;
        OP = 5'h0D;
        e.out = 32'h1234_0000; e.z = 1'b0; e.v = 1'b0; e.name = "lui_before_async";
        exp_q.push_back(e);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        e.out = '0; e.z = 1'b1; e.v = 1'b0; e.name = "async_reset";
        check("async_reset", OUT, zero, ovf, e);
        @(negedge clk);
        rst = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending results, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
